// File: rtl/aes_inv_round_ctrl_if.sv
// ---------------------------------------------------------------------------
// aes_inv_round_ctrl_if
// Host-side block interface of the iterative AES-128 decryption controller.
//   in_valid / in_ready / in_data    : ciphertext block, valid/ready handshake
//   out_valid / out_ready / out_data : plaintext block, valid/ready handshake
// Modports:
//   master : the host (offers ciphertext, consumes plaintext)
//   slave  : the controller
// ---------------------------------------------------------------------------
interface aes_inv_round_ctrl_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/aes_inv_round_ctrl.sv
// ---------------------------------------------------------------------------
// aes_inv_round_ctrl
// Iterative AES-128 decryption engine: one inverse round per clock over a
// single 128-bit state register, round keys fetched from an external
// combinational key store by index.
// Ports:
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   host        : aes_inv_round_ctrl_if.slave (ciphertext in, plaintext out)
//   key_idx     : round-key index requested (0..10), combinational
//   round_key   : key for key_idx, valid in the same cycle
//   busy        : high while rounds are being computed (ROUND, FINAL)
// Build option:
//   AES_INV_BACK_TO_BACK_EN : accept the next block directly from DONE,
//                             skipping the IDLE turnaround cycle.
// State byte order is column-major: S(r,c) = s[127-8*(4c+r) -: 8].
// ---------------------------------------------------------------------------
module aes_inv_round_ctrl #(
   parameter int NR     = 10,
   parameter int KIDX_W = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   aes_inv_round_ctrl_if.slave host,
   output logic [KIDX_W-1:0]   key_idx,
   input  logic [127:0]        round_key,
   output logic                busy
);

   typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

   state_t              state_q, state_d;
   logic [KIDX_W-1:0]   rcnt_q, rcnt_d;
   logic [127:0]        st_q, st_d;
   logic [127:0]        core;

   // ---------------- GF(2^8) helpers ----------------
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (square-and-multiply); maps 0 to 0.
   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] r;
      sq = a;
      r  = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq = gmul(sq, sq);
         r  = gmul(r, sq);
      end
      return r;
   endfunction

   // Inverse S-box: undo the affine map (rotations 1,3,6 and constant 0x05),
   // then invert in the field.
   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      logic [7:0] t;
      t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
      return ginv(t);
   endfunction

   // InvShiftRows followed by InvSubBytes: row r rotates right by r columns.
   function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
      return o;
   endfunction

   function automatic logic [127:0] inv_mix(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09);
         o[119-32*c -: 8] = gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d);
         o[111-32*c -: 8] = gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b);
         o[103-32*c -: 8] = gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e);
      end
      return o;
   endfunction

   // Shared by ROUND and FINAL; ROUND additionally applies InvMixColumns.
   assign core = inv_shift_sub(st_q) ^ round_key;

   // ---------------- next state / outputs ----------------
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one
      // unassigned, which would otherwise infer a latch.
      state_d        = state_q;
      rcnt_d         = rcnt_q;
      st_d           = st_q;
      key_idx        = '0;
      busy           = 1'b0;
      host.in_ready  = 1'b0;
      host.out_valid = 1'b0;
      host.out_data  = '0;

      unique case (state_q)
         IDLE: begin
            host.in_ready = 1'b1;
            key_idx       = KIDX_W'(NR);
            if (host.in_valid) begin
               st_d    = host.in_data ^ round_key;
               rcnt_d  = KIDX_W'(NR - 1);
               state_d = ROUND;
            end
         end
         ROUND: begin
            busy    = 1'b1;
            key_idx = rcnt_q;
            st_d    = inv_mix(core);
            rcnt_d  = rcnt_q - 1'b1;
            // Exit at 1 so the counter never wraps below 0.
            if (rcnt_q == KIDX_W'(1)) state_d = FINAL;
         end
         FINAL: begin
            busy    = 1'b1;
            key_idx = '0;
            st_d    = core;
            state_d = DONE;
         end
         DONE: begin
            host.out_valid = 1'b1;
            host.out_data  = st_q;
`ifdef AES_INV_BACK_TO_BACK_EN
            host.in_ready  = host.out_ready;
            key_idx        = KIDX_W'(NR);
            if (host.out_ready) begin
               if (host.in_valid) begin
                  st_d    = host.in_data ^ round_key;
                  rcnt_d  = KIDX_W'(NR - 1);
                  state_d = ROUND;
               end else begin
                  state_d = IDLE;
               end
            end
`else
            if (host.out_ready) state_d = IDLE;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rcnt_q  <= '0;
         st_q    <= '0;
      end else begin
         state_q <= state_d;
         rcnt_q  <= rcnt_d;
         st_q    <= st_d;
      end
   end

endmodule

// File: doc/aes_inv_round_ctrl.md
Name: aes_inv_round_ctrl

Overview:
- Iterative AES-128 decryption engine controller.
- Sequences the inverse round datapath (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns) over one 128-bit state register, one round per clock.
- Fetches round keys from an external key store by index.
- Sits between the host block interface (valid/ready) and the combinational inverse-round primitives.
- State byte order is column-major: S(r,c) = in[127-8*(4c+r) -: 8].

Parameters:
- NR, 10, number of rounds; only 10 is supported (AES-128).
- KIDX_W, 4, width of the round-key index.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  ciphertext block offered.
- in_ready  output  1  controller can accept a block.
- in_data  input  128  ciphertext block.
- key_idx  output  KIDX_W  round-key index requested, combinational from state and round counter.
- round_key  input  128  key for key_idx; key store is combinational, valid in the same cycle.
- out_valid  output  1  plaintext available.
- out_ready  input  1  consumer accepts plaintext.
- out_data  output  128  plaintext block.
- busy  output  1  high in the ROUND and FINAL states.

Behaviour:
- Reset values:
  - state = IDLE, round counter = 0, state register = 0.
  - in_ready = 1, out_valid = 0, busy = 0, out_data = 0.
- FSM states: IDLE, ROUND, FINAL, DONE.
- IDLE:
  - in_ready = 1, key_idx = 10.
  - On in_valid && in_ready: state reg <= in_data ^ round_key, rcnt <= 9, go to ROUND.
- ROUND:
  - key_idx = rcnt.
  - Each cycle: state reg <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(s)), round_key)).
  - rcnt decrements each cycle.
  - When rcnt == 1 at the edge, go to FINAL.
- FINAL:
  - key_idx = 0.
  - state reg <= AddRoundKey(InvSubBytes(InvShiftRows(s)), round_key); no InvMixColumns.
  - Go to DONE.
- DONE:
  - out_valid = 1, out_data = state reg, in_ready = 0.
  - On out_ready: go to IDLE.
  - out_data and out_valid hold stable while out_ready is low.
- Latency: the handshake edge is edge 0. Rounds 9..1 occupy edges 1..9, the final round is edge 10, and out_valid is high after edge 10. That is 11 cycles from the accept cycle to the first out_valid cycle.
- Throughput: one block per 12 cycles minimum (IDLE turnaround), unless the optional feature below is enabled.
- in_ready is low in ROUND, FINAL and DONE. in_valid in those states is ignored; the data is not captured.
- key_idx is only 0..10. An out-of-range key_idx is never driven.
- round_key is sampled only at the clock edge of the state that consumes it. Key store contents must not change while busy; the controller does not check this.
- Simultaneous events in DONE with out_ready = 1: IDLE is entered; a new in_valid in that same cycle is not accepted (in_ready = 0).
- Reset mid-operation: all state clears immediately (asynchronous). The partial block is discarded and out_valid drops in the same cycle rst_n falls. No output is produced for that block after reset releases.
- rcnt is 4 bits. It never wraps, because the ROUND-to-FINAL exit occurs at rcnt == 1.

Optional Feature:
- Macro: AES_INV_BACK_TO_BACK_EN.
- Defined:
  - In DONE, in_ready = out_ready.
  - On out_ready && in_valid in DONE, the new block is loaded (in_data ^ round_key, key_idx = 10 in DONE) and the FSM goes directly to ROUND, skipping IDLE.
  - Sustained throughput becomes one block per 11 cycles.
- Not defined:
  - DONE always returns to IDLE.
  - in_ready = 0 in DONE.
  - key_idx in DONE is a don't-care, driven 0.

Test Plan:
1. FIPS-197 C.1 vector: model key store holds the expansion of key 000102030405060708090a0b0c0d0e0f. Send in_data = 69c4e0d86a7b0430d8cdb78070b4c55a. Required: out_data = 00112233445566778899aabbccddeeff, and out_valid rises exactly 11 cycles after the accept cycle.
2. Key index sequence: capture key_idx on each cycle of an operation. Required: 10 (accept), 9, 8, ..., 1, 0, with busy high for exactly 10 cycles.
3. Output backpressure: hold out_ready = 0 for 5 cycles in DONE. Required: out_valid and out_data stable, in_ready = 0, and an in_valid pulse during this time is not captured. After out_ready, IDLE is entered and in_ready = 1.
4. Reset mid-operation: assert rst_n = 0 at ROUND with rcnt = 5. Required: out_valid = 0, in_ready = 1 and busy = 0 in the same cycle. After release, the next block (vector 1) decrypts correctly.
5. Two back-to-back blocks, vector 1 then ciphertext of 00000000000000000000000000000000 under the same key, with out_ready tied high:
   - Required: both plaintexts correct and in order.
   - Accept spacing is 12 cycles without AES_INV_BACK_TO_BACK_EN and 11 cycles with it.
6. in_valid held high during busy with changing in_data. Required: only the first block is captured and out_data matches that block only.
